xadc_avg_filter: RTL and testbench

- Moving-average stage between the XADC DRP read path and the 8-bit `dac` driver.
- Accepts one raw XADC conversion word per `in_valid` pulse and keeps a running sum over the last 2^LOG2_TAPS samples.
- Emits the truncated average as an `OUT_W`-bit code, held steady between updates, for the DAC to consume at its own divided rate.

---
 rtl/xadc_avg_filter.sv | 94 +++++++++
 tb/tb_xadc_avg_filter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xadc_avg_filter.sv
// Moving-average filter between the XADC DRP read path and the DAC driver.
// Keeps a running sum over the last 2^LOG2_TAPS 12-bit samples and emits the truncated average.
module xadc_avg_filter #(
  parameter int unsigned LOG2_TAPS = 3,
  parameter int unsigned OUT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clear,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             primed
);

  localparam int unsigned TAPS  = 1 << LOG2_TAPS;
  localparam int unsigned SUM_W = 12 + LOG2_TAPS;
  localparam int unsigned CNT_W = LOG2_TAPS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  logic [11:0]          r_buf [TAPS];
  logic [SUM_W-1:0]     r_sum;
  logic [LOG2_TAPS-1:0] r_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_primed;
  logic                 r_pend;
  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_out_data;

  logic [11:0]      w_sample;
  logic [3:0]       w_unused_lsb;
  logic [11:0]      w_oldest;
  logic             w_accept;
  logic [SUM_W-1:0] w_sum_next;
  logic [OUT_W-1:0] w_avg_trunc;

  assign w_sample     = in_data[15:4];
  assign w_unused_lsb = in_data[3:0];
  assign w_accept     = in_valid & ~clear;
  assign w_oldest     = r_buf[r_ptr];
  // True value is never negative, so modular add/sub at SUM_W bits is exact.
  assign w_sum_next   = r_sum + SUM_W'(w_sample) - SUM_W'(w_oldest);
  // Top OUT_W bits of sum equal avg[11:12-OUT_W] since avg = sum >> LOG2_TAPS.
  assign w_avg_trunc  = r_sum[SUM_W-1 -: OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[r_ptr] <= w_sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_primed <= 1'b0;
    end else if (clear) begin
      r_sum    <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_primed <= 1'b0;
    end else if (w_accept) begin
      r_sum <= w_sum_next;
      r_ptr <= r_ptr + 1'b1;
      if (r_count != CNT_FULL) r_count <= r_count + 1'b1;
      if (r_count == CNT_LAST) r_primed <= 1'b1;
    end
  end

  // Output stage trails the accept by one edge; a clear does not cancel a pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_pend      <= w_accept;
      r_out_valid <= r_pend;
      if (r_pend) r_out_data <= w_avg_trunc;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign primed    = r_primed;

endmodule

// File: tb/tb_xadc_avg_filter.sv
// Directed self-checking bench for xadc_avg_filter (LOG2_TAPS=3, OUT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xadc_avg_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        primed;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ramp [8] = '{8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};
  logic [11:0] m_buf [8];
  int          m_ptr;
  int          m_sum;
  logic [7:0]  b2b_exp [16];

  xadc_avg_filter #(
    .LOG2_TAPS(3),
    .OUT_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clear    (clear),
    .out_valid(out_valid),
    .out_data (out_data),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle in_valid pulse; returns at the falling edge after the accepting edge.
  task automatic send(input logic [15:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [15:0] d);
    send(d);
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    clear    = 1'b0;
    #2;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_primed", {31'd0, primed}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Priming ramp with 3-cycle spacing
    for (int k = 0; k < 8; k++) begin
      send(16'hFFF0);
      check("ramp_valid_early", {31'd0, out_valid}, 32'd0);
      check("ramp_primed", {31'd0, primed}, (k == 7) ? 32'd1 : 32'd0);
      @(negedge clk);
      check("ramp_valid", {31'd0, out_valid}, 32'd1);
      check("ramp_data", {24'd0, out_data}, {24'd0, ramp[k]});
      @(negedge clk);
      check("ramp_valid_late", {31'd0, out_valid}, 32'd0);
    end

    // Step response
    do_clear();
    for (int k = 0; k < 8; k++) send_wait(16'h8000);
    check("step_prime_data", {24'd0, out_data}, 32'h80);
    check("step_prime_primed", {31'd0, primed}, 32'd1);
    for (int k = 0; k < 4; k++) send_wait(16'h4000);
    check("step_half", {24'd0, out_data}, 32'h60);
    for (int k = 0; k < 4; k++) send_wait(16'h4000);
    check("step_full", {24'd0, out_data}, 32'h40);
    for (int k = 0; k < 2; k++) send_wait(16'h4000);
    check("step_hold", {24'd0, out_data}, 32'h40);

    // Back-to-back, alternating words whose low nibble must be ignored
    do_clear();
    check("b2b_cleared_primed", {31'd0, primed}, 32'd0);
    for (int i = 0; i < 8; i++) m_buf[i] = 12'h000;
    m_ptr = 0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = (i % 2 == 1) ? 16'hFFFF : 16'h000F;
      m_buf[m_ptr] = w[15:4];
      m_ptr = (m_ptr + 1) % 8;
      m_sum = 0;
      for (int j = 0; j < 8; j++) m_sum += int'(m_buf[j]);
      b2b_exp[i] = 8'((m_sum >> 3) >> 4);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_data", {24'd0, out_data}, {24'd0, b2b_exp[i-2]});
      end
      in_valid = 1'b1;
      in_data  = (i % 2 == 1) ? 16'hFFFF : 16'h000F;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid_14", {31'd0, out_valid}, 32'd1);
    check("b2b_data_14", {24'd0, out_data}, {24'd0, b2b_exp[14]});
    @(negedge clk);
    check("b2b_valid_15", {31'd0, out_valid}, 32'd1);
    check("b2b_final", {24'd0, out_data}, 32'h7F);
    @(negedge clk);
    check("b2b_valid_end", {31'd0, out_valid}, 32'd0);

    // Clear colliding with a valid sample
    for (int k = 0; k < 8; k++) send_wait(16'hFFF0);
    check("clr_pre_data", {24'd0, out_data}, 32'hFF);
    check("clr_pre_primed", {31'd0, primed}, 32'd1);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_primed", {31'd0, primed}, 32'd0);
    check("clr_hold_data", {24'd0, out_data}, 32'hFF);
    @(negedge clk);
    check("clr_no_pulse", {31'd0, out_valid}, 32'd0);
    check("clr_hold_data2", {24'd0, out_data}, 32'hFF);
    send(16'h8000);
    @(negedge clk);
    check("clr_next_valid", {31'd0, out_valid}, 32'd1);
    check("clr_next_data", {24'd0, out_data}, 32'h10);

    // Async reset while in_valid toggles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = 16'hFFF0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_primed", {31'd0, primed}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_wait(16'h8000);
    check("arst_first", {24'd0, out_data}, 32'h10);
    for (int k = 1; k < 7; k++) send_wait(16'h8000);
    check("arst_primed_7", {31'd0, primed}, 32'd0);
    send_wait(16'h8000);
    check("arst_primed_8", {31'd0, primed}, 32'd1);
    check("arst_data_8", {24'd0, out_data}, 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
